// File: rtl/hpu_axil_regs.sv
// AXI-Lite slave register file for the HPU control path: command register,
// read-write control words, sampled read-only status words and write pulses.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a write (AW/W) or, failing that, a read (AR)
// S_AW    | write address captured, waiting for write data
// S_W     | write data captured, waiting for write address
// S_BRESP | write committed, holding the write response until BREADY
// S_RDEC  | read address captured, selecting and registering read data
// S_RRESP | holding read data/response until RREADY
module hpu_axil_regs #(
  parameter int ADDR_W   = 12,
  parameter int NUM_CTRL = 8,
  parameter int NUM_STAT = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [ADDR_W-1:0]                              s_awaddr,
  input  logic                                           s_awvalid,
  output logic                                           s_awready,
  input  logic [31:0]                                    s_wdata,
  input  logic [3:0]                                     s_wstrb,
  input  logic                                           s_wvalid,
  output logic                                           s_wready,
  output logic [1:0]                                     s_bresp,
  output logic                                           s_bvalid,
  input  logic                                           s_bready,
  input  logic [ADDR_W-1:0]                              s_araddr,
  input  logic                                           s_arvalid,
  output logic                                           s_arready,
  output logic [31:0]                                    s_rdata,
  output logic [1:0]                                     s_rresp,
  output logic                                           s_rvalid,
  input  logic                                           s_rready,
  output logic                                           run,
  output logic                                           gen,
  input  logic                                           gen_done,
  output logic [32*NUM_CTRL-1:0]                         ctrl,
  output logic [NUM_CTRL-1:0]                            wr_pulse,
  input  logic [32*((NUM_STAT > 0) ? NUM_STAT : 1)-1:0]  stat
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_BRESP, S_RDEC, S_RRESP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_aw_idx, r_ar_idx, w_wr_idx_raw;
  logic [31:0]       r_wdata, w_wdata;
  logic [3:0]        r_wstrb, w_wstrb;
  logic [31:0]       r_ctrl [NUM_CTRL];
  logic [NUM_CTRL-1:0] r_wr_pulse;
  logic [1:0]        r_bresp, r_rresp, w_rd_resp;
  logic [31:0]       r_rdata, w_rd_data;
  logic [31:0]       w_wr_idx, w_rd_idx;
  logic              w_commit, w_wr_mapped;
  logic              w_unused;

  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (s_awvalid && s_wvalid) w_state_nxt = S_BRESP;
        else if (s_awvalid)        w_state_nxt = S_AW;
        else if (s_wvalid)         w_state_nxt = S_W;
        else if (s_arvalid)        w_state_nxt = S_RDEC;
      end
      S_AW:    if (s_wvalid)  w_state_nxt = S_BRESP;
      S_W:     if (s_awvalid) w_state_nxt = S_BRESP;
      S_BRESP: if (s_bready)  w_state_nxt = S_IDLE;
      S_RDEC:                 w_state_nxt = S_RRESP;
      S_RRESP: if (s_rready)  w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_awready = (r_state == S_IDLE) || (r_state == S_W);
    s_wready  = (r_state == S_IDLE) || (r_state == S_AW);
    s_arready = (r_state == S_IDLE);
    s_bvalid  = (r_state == S_BRESP);
    s_rvalid  = (r_state == S_RRESP);
  end

  // Whichever half of the write arrived earlier comes from the capture regs.
  assign w_wr_idx_raw = (r_state == S_AW) ? r_aw_idx : s_awaddr[ADDR_W-1:2];
  assign w_wdata      = (r_state == S_W)  ? r_wdata  : s_wdata;
  assign w_wstrb      = (r_state == S_W)  ? r_wstrb  : s_wstrb;
  assign w_wr_idx     = 32'(w_wr_idx_raw);
  assign w_rd_idx     = 32'(r_ar_idx);
  assign w_wr_mapped  = (w_wr_idx < NUM_CTRL);
  assign w_commit     = (r_state != S_BRESP) && (w_state_nxt == S_BRESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_idx <= '0;
      r_ar_idx <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (s_awvalid && s_awready) r_aw_idx <= s_awaddr[ADDR_W-1:2];
      if (s_wvalid && s_wready) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end
      if (r_state == S_IDLE && s_arvalid && !s_awvalid && !s_wvalid)
        r_ar_idx <= s_araddr[ADDR_W-1:2];
    end
  end

  // gen_done clear is applied first so a same-edge command write overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '{default: '0};
      r_wr_pulse <= '0;
      r_bresp    <= 2'b00;
    end else begin
      r_wr_pulse <= '0;
      if (gen_done) r_ctrl[0][0] <= 1'b0;
      if (w_commit) begin
        r_bresp <= w_wr_mapped ? 2'b00 : 2'b10;
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (w_wr_idx == i) begin
            r_wr_pulse[i] <= 1'b1;
            for (int k = 0; k < 4; k++)
              if (w_wstrb[k]) r_ctrl[i][8*k +: 8] <= w_wdata[8*k +: 8];
          end
        end
      end
      r_ctrl[0][31:2] <= '0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = 2'b10;
    if (w_rd_idx < NUM_CTRL) begin
      w_rd_resp = 2'b00;
      for (int i = 0; i < NUM_CTRL; i++)
        if (w_rd_idx == i) w_rd_data = r_ctrl[i];
    end else if (w_rd_idx < NUM_CTRL + NUM_STAT) begin
      w_rd_resp = 2'b00;
      for (int j = 0; j < NUM_STAT; j++)
        if (w_rd_idx == NUM_CTRL + j) w_rd_data = stat[32*j +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (r_state == S_RDEC) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
    assign ctrl[32*gi +: 32] = r_ctrl[gi];
  end

  assign wr_pulse = r_wr_pulse;
  assign s_bresp  = r_bresp;
  assign s_rdata  = r_rdata;
  assign s_rresp  = r_rresp;
  assign run      = r_ctrl[0][1];
  assign gen      = r_ctrl[0][0];

endmodule

// File: tb/tb_hpu_axil_regs.sv
// Directed bench for hpu_axil_regs with default parameters (8 ctrl, 4 stat).
module tb_hpu_axil_regs;
  localparam int ADDR_W = 12;
  localparam int NC = 8;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic run, gen, gen_done;
  logic [32*NC-1:0] ctrl;
  logic [NC-1:0] wr_pulse;
  logic [32*NS-1:0] stat;

  int n_checks = 0;
  int n_fail = 0;

  hpu_axil_regs #(.ADDR_W(ADDR_W), .NUM_CTRL(NC), .NUM_STAT(NS)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .run(run), .gen(gen), .gen_done(gen_done),
    .ctrl(ctrl), .wr_pulse(wr_pulse), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Simultaneous AW+W write with BREADY high; returns response and whether BVALID came.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp, output logic ok);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    tick;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    ok = 1'b0; resp = 2'bxx;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (s_bvalid) begin ok = 1'b1; resp = s_bresp; end
      else tick;
    end
    tick;
  endtask

  // Read with RREADY high; lat counts cycles from AR handshake to RVALID.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    tick;
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 10) begin tick; lat++; end
    d = s_rdata; resp = s_rresp;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    n_checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111", {s_awready, s_wready, s_arready});
    end
    n_checks++;
    if ({s_bvalid, s_rvalid, s_bresp, s_rresp} !== 6'b0) begin
      n_fail++; $display("FAIL reset_resp: got %b want 000000", {s_bvalid, s_rvalid, s_bresp, s_rresp});
    end
    n_checks++;
    if ({run, gen, wr_pulse} !== '0 || s_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: run/gen/pulse %b rdata %h want 0", {run, gen, wr_pulse}, s_rdata);
    end
    n_checks++;
    if (ctrl !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl);
    end
  endtask

  task automatic test_cmd_write;
    logic [1:0] resp; logic ok; logic [31:0] d; int lat;
    s_awaddr = 12'h000; s_wdata = 32'h3; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    tick;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n_checks++;
    if ({run, gen} !== 2'b11 || s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      n_fail++; $display("FAIL cmd_write: run/gen %b bvalid %b bresp %b want 11 1 00", {run, gen}, s_bvalid, s_bresp);
    end
    n_checks++;
    if (wr_pulse !== 8'h01) begin
      n_fail++; $display("FAIL cmd_pulse_on: got %h want 01", wr_pulse);
    end
    tick;
    n_checks++;
    if (wr_pulse !== 8'h00 || s_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL cmd_pulse_off: pulse %h bvalid %b want 00 0", wr_pulse, s_bvalid);
    end
    do_write(12'h000, 32'hFFFF_FFFF, 4'hF, resp, ok);
    n_checks++;
    if (ctrl[31:0] !== 32'h3 || !ok) begin
      n_fail++; $display("FAIL cmd_mask: got %h ok %b want 00000003 1", ctrl[31:0], ok);
    end
    do_read(12'h000, d, resp, lat);
    n_checks++;
    if (d !== 32'h3 || resp !== 2'b00) begin
      n_fail++; $display("FAIL cmd_read: got %h/%b want 00000003/00", d, resp);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] r1, r2, rr; logic ok1, ok2; logic [31:0] d; int lat;
    do_write(12'h004, 32'hAABB_CCDD, 4'hF, r1, ok1);
    do_write(12'h004, 32'h1122_3344, 4'h5, r2, ok2);
    n_checks++;
    if (ctrl[63:32] !== 32'hAA22_CC44) begin
      n_fail++; $display("FAIL strobe_ctrl: got %h want aa22cc44", ctrl[63:32]);
    end
    n_checks++;
    if ({ok1, ok2, r1, r2} !== 6'b110000) begin
      n_fail++; $display("FAIL strobe_resp: got %b want 110000", {ok1, ok2, r1, r2});
    end
    do_read(12'h004, d, rr, lat);
    n_checks++;
    if (d !== 32'hAA22_CC44 || lat !== 2) begin
      n_fail++; $display("FAIL strobe_read: got %h lat %0d want aa22cc44 lat 2", d, lat);
    end
  endtask

  task automatic test_split_backpressure;
    s_awaddr = 12'h008; s_awvalid = 1'b1; s_bready = 1'b0;
    tick;
    s_awvalid = 1'b0;
    n_checks++;
    if ({s_awready, s_wready} !== 2'b01) begin
      n_fail++; $display("FAIL split_aw_ready: got %b want 01", {s_awready, s_wready});
    end
    tick; tick;
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick;
    s_wvalid = 1'b0;
    n_checks++;
    if (s_bvalid !== 1'b1 || wr_pulse !== 8'h04 || ctrl[95:64] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL split_commit: bvalid %b pulse %h reg2 %h want 1 04 12345678", s_bvalid, wr_pulse, ctrl[95:64]);
    end
    s_awaddr = 12'h00C; s_wdata = 32'hFFFF_FFFF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if ({s_bvalid, wr_pulse, s_awready, s_wready, s_arready} !== {1'b1, 8'h00, 3'b000}) begin
        n_fail++; $display("FAIL split_hold%0d: got %b want 1_00000000_000", i, {s_bvalid, wr_pulse, s_awready, s_wready, s_arready});
      end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    tick;
    n_checks++;
    if (s_bvalid !== 1'b0 || ctrl[127:96] !== 32'h0 || ctrl[95:64] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL split_release: bvalid %b reg3 %h reg2 %h want 0 0 12345678", s_bvalid, ctrl[127:96], ctrl[95:64]);
    end
  endtask

  task automatic test_stat_read;
    logic [31:0] d; logic [1:0] r; int lat;
    stat = '0;
    stat[31:0] = 32'hDEAD_BEEF;
    stat[127:96] = 32'hCAFE_F00D;
    do_read(12'h020, d, r, lat);
    n_checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat !== 2) begin
      n_fail++; $display("FAIL stat0_read: got %h/%b lat %0d want deadbeef/00 lat 2", d, r, lat);
    end
    do_read(12'h02E, d, r, lat);
    n_checks++;
    if (d !== 32'hCAFE_F00D || r !== 2'b00) begin
      n_fail++; $display("FAIL stat3_read: got %h/%b want cafef00d/00", d, r);
    end
    do_read(12'h030, d, r, lat);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_fail++; $display("FAIL unmapped_read: got %h/%b want 00000000/10", d, r);
    end
    stat[63:32] = 32'h0BAD_C0DE;
    s_araddr = 12'h024; s_arvalid = 1'b1; s_rready = 1'b0;
    tick;
    s_arvalid = 1'b0;
    tick;
    stat[63:32] = 32'h0;
    tick; tick;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== 32'h0BAD_C0DE || s_arready !== 1'b0) begin
      n_fail++; $display("FAIL read_hold: rvalid %b data %h arready %b want 1 0badc0de 0", s_rvalid, s_rdata, s_arready);
    end
    s_rready = 1'b1;
    tick;
    n_checks++;
    if (s_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_release: rvalid %b want 0", s_rvalid);
    end
  endtask

  task automatic test_gen_done;
    logic [1:0] r; logic ok;
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;
    n_checks++;
    if ({run, gen} !== 2'b10) begin
      n_fail++; $display("FAIL gen_done_clear: run/gen %b want 10", {run, gen});
    end
    do_write(12'h000, 32'h3, 4'hF, r, ok);
    s_awaddr = 12'h000; s_wdata = 32'h1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1; gen_done = 1'b1;
    tick;
    s_awvalid = 1'b0; s_wvalid = 1'b0; gen_done = 1'b0;
    n_checks++;
    if ({run, gen} !== 2'b01) begin
      n_fail++; $display("FAIL gen_write_wins: run/gen %b want 01", {run, gen});
    end
    tick;
  endtask

  task automatic test_stat_write;
    logic [32*NC-1:0] exp_ctrl;
    logic [1:0] r; logic ok;
    exp_ctrl = '0;
    exp_ctrl[31:0] = 32'h1;
    exp_ctrl[63:32] = 32'hAA22_CC44;
    exp_ctrl[95:64] = 32'h1234_5678;
    s_awaddr = 12'h020; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    tick;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n_checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b10 || wr_pulse !== 8'h00) begin
      n_fail++; $display("FAIL stat_write: bvalid %b bresp %b pulse %h want 1 10 00", s_bvalid, s_bresp, wr_pulse);
    end
    tick;
    do_write(12'h040, 32'hFFFF_FFFF, 4'hF, r, ok);
    n_checks++;
    if (r !== 2'b10 || !ok) begin
      n_fail++; $display("FAIL unmapped_write: bresp %b ok %b want 10 1", r, ok);
    end
    n_checks++;
    if (ctrl !== exp_ctrl) begin
      n_fail++; $display("FAIL stat_write_ctrl: got %h want %h", ctrl, exp_ctrl);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic ok;
    s_awaddr = 12'h014; s_awvalid = 1'b1; s_bready = 1'b1;
    tick;
    s_awvalid = 1'b0;
    s_wdata = 32'h5555_5555; s_wstrb = 4'hF; s_wvalid = 1'b1; rst = 1'b1;
    tick;
    s_wvalid = 1'b0; rst = 1'b0;
    n_checks++;
    if ({s_bvalid, wr_pulse, s_awready, s_wready, s_arready} !== {1'b0, 8'h00, 3'b111}) begin
      n_fail++; $display("FAIL reset_mid_state: got %b want 0_00000000_111", {s_bvalid, wr_pulse, s_awready, s_wready, s_arready});
    end
    tick;
    n_checks++;
    if (ctrl !== '0 || s_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_commit: ctrl %h bvalid %b want 0 0", ctrl, s_bvalid);
    end
    do_write(12'h014, 32'h0000_0055, 4'hF, r, ok);
    n_checks++;
    if (ctrl[191:160] !== 32'h55 || r !== 2'b00 || !ok) begin
      n_fail++; $display("FAIL reset_mid_resume: reg5 %h bresp %b ok %b want 00000055 00 1", ctrl[191:160], r, ok);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    gen_done = 1'b0; stat = '0;
    test_reset;
    test_cmd_write;
    test_strobe;
    test_split_backpressure;
    test_stat_read;
    test_gen_done;
    test_stat_write;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hpu_axil_regs.md
# hpu_axil_regs

Parametrised AXI-Lite slave register file for the HPU control path, the successor to the fixed two-register decoder in the HPU top level. Provides a command register (`run`/`gen`), `NUM_CTRL-1` read-write control words and `NUM_STAT` read-only status words. Adds byte-strobe writes, SLVERR on unmapped addresses, per-register write pulses, and hardware auto-clear of `gen`. Sits between the PS AXI-Lite port and the HPU datapath controllers, all on one clock.

## Interface
Parameters:
- `ADDR_W`, 12: AXI-Lite address width; word index = `addr[ADDR_W-1:2]`, `addr[1:0]` ignored.
- `NUM_CTRL`, 8: read-write registers, indices 0..NUM_CTRL-1; index 0 is the command register. Range 1..256.
- `NUM_STAT`, 4: read-only registers, indices NUM_CTRL..NUM_CTRL+NUM_STAT-1. Range 0..256.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock for all logic.
- `rst` in 1: synchronous active-high reset.
- `s_awaddr` in ADDR_W; `s_awvalid` in 1; `s_awready` out 1: write address channel.
- `s_wdata` in 32; `s_wstrb` in 4; `s_wvalid` in 1; `s_wready` out 1: write data channel.
- `s_bresp` out 2; `s_bvalid` out 1; `s_bready` in 1: write response.
- `s_araddr` in ADDR_W; `s_arvalid` in 1; `s_arready` out 1: read address.
- `s_rdata` out 32; `s_rresp` out 2; `s_rvalid` out 1; `s_rready` in 1: read data.
- `run` out 1: command register bit 1.
- `gen` out 1: command register bit 0.
- `gen_done` in 1: one-cycle pulse from the item-memory generator; clears `gen`.
- `ctrl` out 32*NUM_CTRL: flattened control registers, register i at bits [32i+31:32i].
- `wr_pulse` out NUM_CTRL: bit i high one cycle when register i is written.
- `stat` in 32*NUM_STAT: flattened status words, sampled on read.

## Operation
- FSM states: IDLE, AW (address held), W (data held), BRESP, RDEC, RRESP.
- Ready signals: `s_awready` = IDLE|W; `s_wready` = IDLE|AW; `s_arready` = IDLE; `s_bvalid` = BRESP; `s_rvalid` = RRESP.
- IDLE: AW+W both valid → BRESP; AW only → AW; W only → W; else ARVALID → RDEC. Writes have priority over reads.
- AW: WVALID → BRESP. W: AWVALID → BRESP. BRESP: BREADY → IDLE. RDEC → RRESP unconditionally. RRESP: RREADY → IDLE.
- Write commit on the edge entering BRESP: byte k of register idx updated only if `wstrb[k]`; `wr_pulse[idx]` high for exactly the first BRESP cycle.
- Command register: only bits [1:0] stored; bits 31:2 read 0. `ctrl[31:0]` mirrors it.
- Index ≥ NUM_CTRL (status or unmapped) on write: no register change, no pulse, `s_bresp`=2'b10. Mapped write: 2'b00.
- Read in RDEC: index < NUM_CTRL → ctrl word; status range → `stat` word sampled that cycle; unmapped → 0 with `s_rresp`=2'b10; else 2'b00. `s_rdata`/`s_rresp` held stable through RRESP.
- `gen_done` clears `gen` on the next edge. A command-register write committing on the same edge wins (write value taken).

## Timing
- Reset: state IDLE; all registers 0; `run`=`gen`=0; `wr_pulse`=0; `s_bvalid`=`s_rvalid`=0; `s_bresp`=`s_rresp`=0; `s_rdata`=0; `s_awready`=`s_wready`=`s_arready`=1.
- Write: AW+W same cycle in IDLE → `s_bvalid` and new register value visible the next cycle.
- Read: AR handshake at cycle 0 → `s_rvalid` at cycle 2.
- Backpressure: BRESP/RRESP held indefinitely until ready; no new address accepted meanwhile.
- Reset mid-transaction: abandons the transaction, no commit, no response.

## Test plan
- Reset then write 0x3 to addr 0x000, wstrb 0xF → next cycle `run`=1, `gen`=1, `wr_pulse[0]`=1 for one cycle, `s_bresp`=00.
- Write 0xAABBCCDD to addr 0x004, then 0x11223344 with wstrb 0x5 → `ctrl[63:32]`=0xAA22CC44.
- Present AW at cycle 0 and W at cycle 3 with BREADY low for 4 cycles → one commit, `s_bvalid` held until BREADY, single `wr_pulse`.
- Drive `stat[31:0]`=0xDEADBEEF; read addr 4*NUM_CTRL → `s_rdata`=0xDEADBEEF, `s_rvalid` 2 cycles after AR. Read addr 4*(NUM_CTRL+NUM_STAT) → data 0, `s_rresp`=10.
- `gen`=1; pulse `gen_done` → `gen`=0 next cycle, `run` unchanged. Repeat with a same-edge command write of 0x1 → `gen` stays 1.
- Write to a status address → `s_bresp`=10, no `wr_pulse`, no register change. Assert `rst` during AW state → returns to IDLE, no commit.
